hazard_scoreboard: RTL and testbench

- Next-generation hazard unit for the scalar/vector (SIMD) 5-stage pipeline; replaces the purely combinational unit that relied on an external `busy` input.
- Keeps M/W forwarding and decode-stage branch forwarding for both register files.
- Adds an internal multicycle-unit tracker: an FSM with a latency countdown, a per-register pending-write scoreboard per file, structural-hazard stalls and a saturating stall-cycle counter.

---
 rtl/hazard_scoreboard.sv | 246 ++++++++++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//
// Hazard unit for the scalar/vector 5-stage pipeline. It provides:
//   - M/W operand forwarding in E for both register files
//   - M forwarding into the decode-stage branch comparator (scalar only)
//   - load-use and branch stalls
//   - a multicycle-unit tracker: IDLE/RUN/WB FSM with a latency countdown,
//     one pending-write scoreboard per register file and a structural stall
//     when a second multicycle op reaches E while the unit is still running
//   - a saturating count of cycles in which fetch was stalled
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   rsD, rtD, rsE, rtE            source registers in D and E
//   vsrcD, vsrcE                  D/E sources are vector registers
//   writeregE/M/W                 destination registers in E/M/W
//   regwriteE/M/W, VregwriteE/M/W scalar / vector write enables
//   memtoregE, memtoregM          load in E / M
//   branchD                       branch type in D (nonzero = branch)
//   mc_issueE, mc_latE, mc_vecE   multicycle op in E, its latency, vector dest
//   forwardaD, forwardbD          branch operand forward from M
//   forwardaE/bE, VforwardaE/bE   operand select: 10 = M, 01 = W, 00 = RF
//   stallF..stallW, flushE        pipeline control
//   mc_busy, mc_done              unit not idle / one pulse per writeback
//   mc_dest, mc_dest_vec          destination of the in-flight op
//   stall_cycles                  saturating count of stallF cycles
//
// Handshake: a multicycle op is accepted on the clock edge where
// mc_issueE=1 and stallE=0 (in IDLE or WB). While RUN, a new mc_issueE
// raises stallE so the op is held in E until the unit reaches WB.
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int REG_AW         = 5,
  parameter int LAT_W          = 4,
  parameter int CNT_W          = 16,
  parameter int ZERO_HARDWIRED = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rsD,
  input  logic [REG_AW-1:0] rtD,
  input  logic [REG_AW-1:0] rsE,
  input  logic [REG_AW-1:0] rtE,
  input  logic              vsrcD,
  input  logic              vsrcE,
  input  logic [REG_AW-1:0] writeregE,
  input  logic [REG_AW-1:0] writeregM,
  input  logic [REG_AW-1:0] writeregW,
  input  logic              regwriteE,
  input  logic              regwriteM,
  input  logic              regwriteW,
  input  logic              VregwriteE,
  input  logic              VregwriteM,
  input  logic              VregwriteW,
  input  logic              memtoregE,
  input  logic              memtoregM,
  input  logic [1:0]        branchD,
  input  logic              mc_issueE,
  input  logic [LAT_W-1:0]  mc_latE,
  input  logic              mc_vecE,
  output logic              forwardaD,
  output logic              forwardbD,
  output logic [1:0]        forwardaE,
  output logic [1:0]        forwardbE,
  output logic [1:0]        VforwardaE,
  output logic [1:0]        VforwardbE,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              stallM,
  output logic              stallW,
  output logic              flushE,
  output logic              mc_busy,
  output logic              mc_done,
  output logic [REG_AW-1:0] mc_dest,
  output logic              mc_dest_vec,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int NREG = 1 << REG_AW;
  localparam bit ZH   = (ZERO_HARDWIRED != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WB   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  logic [REG_AW-1:0] dest_q, dest_d;
  logic              dest_vec_q, dest_vec_d;
  logic [NREG-1:0]   sb_s_q, sb_s_d;
  logic [NREG-1:0]   sb_v_q, sb_v_d;
  logic              done_q;
  logic [CNT_W-1:0]  stall_cnt_q;

  // The vector E-stage write enable does not take part in any hazard term;
  // branches only compare scalar registers.
  logic unused_vregwrite_e;
  assign unused_vregwrite_e = VregwriteE;

  // Scalar r0 is hardwired to zero when ZH is set, so it never matches.
  logic live_rsE, live_rtE, live_rsD, live_rtD;
  assign live_rsE = !(ZH && (rsE == '0));
  assign live_rtE = !(ZH && (rtE == '0));
  assign live_rsD = !(ZH && (rsD == '0));
  assign live_rtD = !(ZH && (rtD == '0));

  // ------------------------------------------------------------------
  // E-stage operand forwarding (M has priority over W)
  // ------------------------------------------------------------------
  always_comb begin
    forwardaE  = 2'b00;
    forwardbE  = 2'b00;
    VforwardaE = 2'b00;
    VforwardbE = 2'b00;
    if (!vsrcE) begin
      if (live_rsE && regwriteM && (rsE == writeregM))      forwardaE = 2'b10;
      else if (live_rsE && regwriteW && (rsE == writeregW)) forwardaE = 2'b01;
      if (live_rtE && regwriteM && (rtE == writeregM))      forwardbE = 2'b10;
      else if (live_rtE && regwriteW && (rtE == writeregW)) forwardbE = 2'b01;
    end else begin
      if (VregwriteM && (rsE == writeregM))      VforwardaE = 2'b10;
      else if (VregwriteW && (rsE == writeregW)) VforwardaE = 2'b01;
      if (VregwriteM && (rtE == writeregM))      VforwardbE = 2'b10;
      else if (VregwriteW && (rtE == writeregW)) VforwardbE = 2'b01;
    end
  end

  assign forwardaD = !vsrcD && (rsD != '0) && regwriteM && (rsD == writeregM);
  assign forwardbD = !vsrcD && (rtD != '0) && regwriteM && (rtD == writeregM);

  // ------------------------------------------------------------------
  // Hazard terms
  // ------------------------------------------------------------------
  logic lwstall, branchstall, sbstall, mcfwdstall, structstall, stall_any;
  logic [NREG-1:0] pend_s, pend_v;

  assign lwstall = memtoregE && ((rsD == writeregE) || (rtD == writeregE));

  assign branchstall = (branchD != 2'b00) &&
                       ((regwriteE && ((writeregE == rsD) || (writeregE == rtD))) ||
                        (memtoregM && ((writeregM == rsD) || (writeregM == rtD))));

  // During WB the result is being written into the register file, so its
  // pending bit is already hidden from D even though it clears on the edge
  // leaving WB. That lets a new issue to the same register re-set the bit
  // on that edge without any set/clear conflict.
  always_comb begin
    pend_s = sb_s_q;
    pend_v = sb_v_q;
    if (state_q == WB) begin
      if (dest_vec_q) pend_v[dest_q] = 1'b0;
      else            pend_s[dest_q] = 1'b0;
    end
  end

  always_comb begin
    if (vsrcD) sbstall = pend_v[rsD] | pend_v[rtD];
    else       sbstall = (pend_s[rsD] & live_rsD) | (pend_s[rtD] & live_rtD);
  end

  assign mcfwdstall  = mc_issueE && (mc_vecE == vsrcD) &&
                       ((writeregE == rsD) || (writeregE == rtD));
  assign structstall = mc_issueE && (state_q == RUN);
  assign stall_any   = lwstall | branchstall | sbstall | mcfwdstall | structstall;

  assign stallF = stall_any;
  assign stallD = stall_any;
  assign stallE = structstall;
  assign stallM = structstall;
  assign stallW = structstall;
  assign flushE = stall_any & ~structstall;

  // ------------------------------------------------------------------
  // Multicycle tracker
  // ------------------------------------------------------------------
  logic             accept;
  logic [LAT_W-1:0] lat_m1;

  assign accept = mc_issueE && !structstall && (state_q != RUN);
  // A latency of 0 behaves like 1.
  assign lat_m1 = (mc_latE == '0) ? '0 : (mc_latE - LAT_W'(1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dest_d     = dest_q;
    dest_vec_d = dest_vec_q;
    sb_s_d     = sb_s_q;
    sb_v_d     = sb_v_q;
    case (state_q)
      RUN: begin
        if (cnt_q == '0) state_d = WB;
        else             cnt_d   = cnt_q - LAT_W'(1);
      end
      WB: begin
        state_d = IDLE;
        if (dest_vec_q) sb_v_d[dest_q] = 1'b0;
        else            sb_s_d[dest_q] = 1'b0;
      end
      default: ;
    endcase
    // Applied after the WB clear so a back-to-back issue to the same
    // register keeps its bit set.
    if (accept) begin
      dest_d     = writeregE;
      dest_vec_d = mc_vecE;
      cnt_d      = lat_m1;
      if (mc_vecE) sb_v_d[writeregE] = 1'b1;
      else         sb_s_d[writeregE] = 1'b1;
      state_d    = (lat_m1 == '0) ? WB : RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dest_q      <= '0;
      dest_vec_q  <= 1'b0;
      sb_s_q      <= '0;
      sb_v_q      <= '0;
      done_q      <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dest_q     <= dest_d;
      dest_vec_q <= dest_vec_d;
      sb_s_q     <= sb_s_d;
      sb_v_q     <= sb_v_d;
      done_q     <= (state_d == WB);
      if (stall_any && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign mc_busy      = (state_q != IDLE);
  assign mc_done      = done_q;
  assign mc_dest      = dest_q;
  assign mc_dest_vec  = dest_vec_q;
  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int NVEC    = 14;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic       vsrcD, vsrcE;
  logic       regwriteE, regwriteM, regwriteW, VregwriteE, VregwriteM, VregwriteW;
  logic       memtoregE, memtoregM;
  logic [1:0] branchD;
  logic       mc_issueE, mc_vecE;
  logic [3:0] mc_latE;
  logic       forwardaD, forwardbD;
  logic [1:0] forwardaE, forwardbE, VforwardaE, VforwardbE;
  logic       stallF, stallD, stallE, stallM, stallW, flushE;
  logic       mc_busy, mc_done, mc_dest_vec;
  logic [4:0] mc_dest;
  logic [CNT_W-1:0] stall_cycles;

  hazard_scoreboard #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .vsrcD(vsrcD), .vsrcE(vsrcE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .VregwriteE(VregwriteE), .VregwriteM(VregwriteM), .VregwriteW(VregwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM), .branchD(branchD),
    .mc_issueE(mc_issueE), .mc_latE(mc_latE), .mc_vecE(mc_vecE),
    .forwardaD(forwardaD), .forwardbD(forwardbD),
    .forwardaE(forwardaE), .forwardbE(forwardbE),
    .VforwardaE(VforwardaE), .VforwardbE(VforwardbE),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .stallW(stallW), .flushE(flushE),
    .mc_busy(mc_busy), .mc_done(mc_done), .mc_dest(mc_dest),
    .mc_dest_vec(mc_dest_vec), .stall_cycles(stall_cycles)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int exp_cnt  = 0;

  // {done cycle, vector flag, destination}
  logic [37:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, expv, cyc);
  endtask

  // Advance one clock; the model counter follows the expected stallF.
  task automatic step(input logic sf);
    @(posedge clk);
    if (sf && (exp_cnt < CNT_MAX)) exp_cnt++;
    @(negedge clk);
  endtask

  // A latency of L>=2 spends L cycles in RUN then one in WB; L<=1 goes
  // straight to WB on the accepting edge.
  task automatic push_done(input int lat, input logic vec, input logic [4:0] dst);
    int d;
    d = (lat <= 1) ? 1 : lat + 1;
    exp_q.push_back({32'(cyc + d), vec, dst});
  endtask

  // Scoreboard side: every mc_done must match the oldest expectation.
  always @(negedge clk) begin
    logic [37:0] e;
    if (mc_done) begin
      if (exp_q.size() == 0) begin
        check("mc_done_unexpected", 64'(mc_done), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("mc_done_match", 64'({32'(cyc), mc_dest_vec, mc_dest}), 64'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  typedef struct packed {
    logic [4:0] rsd, rtd, rse, rte, we, wm, ww;
    logic       vsd, vse, rwe, rwm, rww, vrwm, vrww, meme, memm;
    logic [1:0] br;
    logic [1:0] fae, fbe, vfae, vfbe;
    logic       fad, fbd, sf, fl;
  } vec_t;

  function automatic vec_t quiet_vec();
    vec_t v;
    v = '0;
    v.rsd = 5'd1; v.rtd = 5'd2; v.rse = 5'd3; v.rte = 5'd4;
    v.we  = 5'd5; v.wm  = 5'd6; v.ww  = 5'd7;
    return v;
  endfunction

  task automatic apply_vec(input vec_t v);
    rsD = v.rsd; rtD = v.rtd; rsE = v.rse; rtE = v.rte;
    writeregE = v.we; writeregM = v.wm; writeregW = v.ww;
    vsrcD = v.vsd; vsrcE = v.vse;
    regwriteE = v.rwe; regwriteM = v.rwm; regwriteW = v.rww;
    VregwriteE = 1'b0; VregwriteM = v.vrwm; VregwriteW = v.vrww;
    memtoregE = v.meme; memtoregM = v.memm; branchD = v.br;
    mc_issueE = 1'b0; mc_latE = 4'd0; mc_vecE = 1'b0;
  endtask

  task automatic set_quiet();
    apply_vec(quiet_vec());
  endtask

  task automatic issue(input logic [3:0] lat, input logic [4:0] dst, input logic vec);
    mc_issueE = 1'b1; mc_latE = lat; writeregE = dst; mc_vecE = vec;
  endtask

  vec_t        tbl[NVEC];
  logic [14:0] got, expv;

  initial begin
    vec_t t;
    // ---------------- vector table ----------------
    t = quiet_vec();                                                        tbl[0]  = t;
    t = quiet_vec(); t.rse=5; t.wm=5; t.ww=5; t.rwm=1; t.rww=1; t.fae=2'b10; tbl[1]  = t;
    t = quiet_vec(); t.rse=5; t.wm=5; t.ww=5; t.rww=1; t.fae=2'b01;          tbl[2]  = t;
    t = quiet_vec(); t.vse=1; t.rse=5; t.ww=5; t.rww=1; t.vrww=1; t.vfae=2'b01; tbl[3] = t;
    t = quiet_vec(); t.vse=1; t.wm=4; t.ww=4; t.vrwm=1; t.vrww=1; t.vfbe=2'b10; tbl[4] = t;
    t = quiet_vec(); t.rse=0; t.rte=0; t.wm=0; t.rwm=1;                     tbl[5]  = t;
    t = quiet_vec(); t.vse=1; t.rse=0; t.wm=0; t.vrwm=1; t.vfae=2'b10;       tbl[6]  = t;
    t = quiet_vec(); t.rsd=6; t.rtd=6; t.rwm=1; t.fad=1; t.fbd=1;            tbl[7]  = t;
    t = quiet_vec(); t.rsd=0; t.wm=0; t.rwm=1;                               tbl[8]  = t;
    t = quiet_vec(); t.meme=1; t.we=2; t.sf=1; t.fl=1;                       tbl[9]  = t;
    t = quiet_vec(); t.br=2'b01; t.rwe=1; t.we=1; t.sf=1; t.fl=1;            tbl[10] = t;
    t = quiet_vec(); t.br=2'b10; t.memm=1; t.wm=2; t.sf=1; t.fl=1;           tbl[11] = t;
    t = quiet_vec(); t.rwe=1; t.we=1;                                        tbl[12] = t;
    t = quiet_vec(); t.rsd=6; t.rwm=1; t.vsd=1;                              tbl[13] = t;

    // ---------------- reset ----------------
    rst_n = 1'b0;
    set_quiet();
    @(negedge clk);
    #1;
    check("rst_busy", 64'(mc_busy), 64'd0);
    check("rst_done", 64'(mc_done), 64'd0);
    check("rst_dest", 64'({mc_dest_vec, mc_dest}), 64'd0);
    check("rst_stall_cycles", 64'(stall_cycles), 64'd0);
    check("rst_stalls", 64'({stallF, stallD, stallE, stallM, stallW, flushE}), 64'd0);
    step(1'b0);
    rst_n = 1'b1;
    step(1'b0);

    // ---------------- table-driven combinational checks ----------------
    for (int i = 0; i < NVEC; i++) begin
      apply_vec(tbl[i]);
      #1;
      got  = {forwardaE, forwardbE, VforwardaE, VforwardbE, forwardaD, forwardbD,
              stallF, stallD, stallE, stallM, stallW, flushE, mc_busy};
      expv = {tbl[i].fae, tbl[i].fbe, tbl[i].vfae, tbl[i].vfbe, tbl[i].fad, tbl[i].fbd,
              tbl[i].sf, tbl[i].sf, 3'b000, tbl[i].fl, 1'b0};
      check($sformatf("vec%0d", i), 64'(got), 64'(expv));
      step(tbl[i].sf);
    end

    // ---------------- load-use: counter steps by one per cycle ----------------
    for (int i = 0; i < 3; i++) begin
      apply_vec(tbl[9]);
      #1;
      check("loaduse_cnt", 64'(stall_cycles), 64'(exp_cnt));
      check("loaduse_stallE", 64'(stallE), 64'd0);
      step(1'b1);
    end
    set_quiet();
    #1;
    check("loaduse_cnt_end", 64'(stall_cycles), 64'(exp_cnt));

    // ---------------- vector multicycle op, lat 3, dest v9 ----------------
    issue(4'd3, 5'd9, 1'b1);
    push_done(3, 1'b1, 5'd9);
    #1;
    check("mc_issue_nostall", 64'({stallF, stallE}), 64'd0);
    step(1'b0);
    for (int i = 0; i < 4; i++) begin
      set_quiet();
      rsD = 5'd9; vsrcD = 1'b0;
      #1;
      check("scalar_r9_nostall", 64'(stallF), 64'd0);
      vsrcD = 1'b1;
      #1;
      check("sbstall_v9", 64'(stallF), 64'(i < 3));
      check("mc_busy_run", 64'(mc_busy), 64'd1);
      step(i < 3);
    end
    set_quiet();
    #1;
    check("mc_idle_after", 64'(mc_busy), 64'd0);

    // ---------------- structural stall and back-to-back issue ----------------
    issue(4'd2, 5'd10, 1'b0);
    push_done(2, 1'b0, 5'd10);
    step(1'b0);
    set_quiet();
    issue(4'd3, 5'd11, 1'b0);
    for (int i = 0; i < 2; i++) begin
      #1;
      check("struct_stalls", 64'({stallF, stallD, stallE, stallM, stallW, flushE}), 64'b111110);
      step(1'b1);
    end
    #1;
    check("wb_accept_stalls", 64'({stallF, stallD, stallE, stallM, stallW, flushE}), 64'd0);
    check("wb_dest_old", 64'(mc_dest), 64'd10);
    push_done(3, 1'b0, 5'd11);
    step(1'b0);
    set_quiet();
    #1;
    check("b2b_no_gap_busy", 64'(mc_busy), 64'd1);
    check("b2b_no_gap_dest", 64'(mc_dest), 64'd11);
    for (int i = 0; i < 4; i++) step(1'b0);

    // ---------------- same-register back-to-back, lat 0 then 2 ----------------
    set_quiet();
    issue(4'd0, 5'd3, 1'b1);
    push_done(0, 1'b1, 5'd3);
    step(1'b0);
    issue(4'd2, 5'd3, 1'b1);
    #1;
    check("wb_issue_stallE", 64'(stallE), 64'd0);
    push_done(2, 1'b1, 5'd3);
    step(1'b0);
    for (int i = 0; i < 3; i++) begin
      set_quiet();
      rsD = 5'd3; vsrcD = 1'b1;
      #1;
      check("set_wins_stall", 64'(stallF), 64'(i < 2));
      step(i < 2);
    end
    set_quiet();
    #1;
    check("set_wins_idle", 64'(mc_busy), 64'd0);

    // ---------------- saturation of the stall counter ----------------
    for (int i = 0; i < 20; i++) begin
      apply_vec(tbl[9]);
      step(1'b1);
    end
    set_quiet();
    #1;
    check("stall_cnt_sat", 64'(stall_cycles), 64'(exp_cnt));

    // ---------------- reset in the middle of RUN ----------------
    issue(4'd5, 5'd12, 1'b1);
    push_done(5, 1'b1, 5'd12);
    step(1'b0);
    set_quiet();
    rsD = 5'd12; vsrcD = 1'b1;
    #1;
    check("pre_reset_stall", 64'(stallF), 64'd1);
    step(1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_cnt = 0;
    check("midrst_busy", 64'(mc_busy), 64'd0);
    check("midrst_done", 64'(mc_done), 64'd0);
    check("midrst_cnt", 64'(stall_cycles), 64'd0);
    check("midrst_sb", 64'(stallF), 64'd0);
    step(1'b0);
    rst_n = 1'b1;
    set_quiet();
    for (int i = 0; i < 12; i++) step(1'b0);
    #1;
    check("post_rst_busy", 64'(mc_busy), 64'd0);
    check("final_cnt", 64'(stall_cycles), 64'(exp_cnt));
    check("done_q_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
